// File: rtl/sar_result_reader.sv
// sar_result_reader
// Captures each completed SAR code on the rising edge of conv_done, buffers it
// in a small circular FIFO and ships it MSB-first as a framed serial word
// (SPI mode 0: sclk idles low, data changes on the falling edge).
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   conv_done  conversion-complete level; a 0->1 transition marks a new code
//   code       SAR result, valid in the first cycle conv_done reads 1
//   clr_ovf    synchronous clear of overflow (a same-cycle drop wins)
//   cs_n       frame select, active low (registered)
//   sclk       serial clock, idle low (registered)
//   sdo        serial data, MSB first (registered)
//   fifo_count current FIFO occupancy
//   overflow   sticky flag: a code was dropped because the FIFO was full
module sar_result_reader #(
  parameter int WIDTH   = 12,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     conv_done,
  input  logic [WIDTH-1:0]         code,
  input  logic                     clr_ovf,
  output logic                     cs_n,
  output logic                     sclk,
  output logic                     sdo,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  logic             conv_done_q_r;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic             accept_s;
  logic             drop_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;

  state_t           state_r, state_nxt_s;
  logic [DW-1:0]    div_cnt_r, div_cnt_nxt_s;
  logic [BW-1:0]    bit_idx_r, bit_idx_nxt_s;
  logic             phase_r, phase_nxt_s;     // 0: sclk low half, 1: sclk high half
  logic [WIDTH-1:0] shift_r, shift_nxt_s;
  logic             cs_n_r, cs_n_nxt_s;
  logic             sclk_r, sclk_nxt_s;
  logic             sdo_r, sdo_nxt_s;

  assign push_s  = conv_done & ~conv_done_q_r;
  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});
  // A pop in the same cycle frees the head slot, so the push is taken even when full.
  assign accept_s = push_s & (~full_s | pop_s);
  assign drop_s   = push_s & full_s & ~pop_s;

  // Edge-detect history of conv_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_done_q_r <= 1'b0;
    end else begin
      conv_done_q_r <= conv_done;
    end
  end

  // FIFO storage; contents need no reset because count_r gates every read.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= code;
    end
  end

  // FIFO pointers, occupancy and sticky overflow (a drop beats clr_ovf).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Transmitter next-state, datapath and output decode.
  always_comb begin
    state_nxt_s   = state_r;
    div_cnt_nxt_s = div_cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    phase_nxt_s   = phase_r;
    shift_nxt_s   = shift_r;
    pop_s         = 1'b0;
    cs_n_nxt_s    = 1'b1;
    sclk_nxt_s    = 1'b0;
    sdo_nxt_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          shift_nxt_s = mem_r[rd_ptr_r];
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        cs_n_nxt_s    = 1'b0;
        sdo_nxt_s     = shift_r[WIDTH-1];
        state_nxt_s   = SHIFT;
        bit_idx_nxt_s = BW'(WIDTH - 1);
        phase_nxt_s   = 1'b0;
        div_cnt_nxt_s = {DW{1'b0}};
      end
      SHIFT: begin
        cs_n_nxt_s = 1'b0;
        sclk_nxt_s = phase_r;
        sdo_nxt_s  = shift_r[WIDTH-1];
        if (div_cnt_r == DW'(CLK_DIV - 1)) begin
          div_cnt_nxt_s = {DW{1'b0}};
          if (!phase_r) begin
            phase_nxt_s = 1'b1;
          end else if (bit_idx_r == {BW{1'b0}}) begin
            phase_nxt_s = 1'b0;
            state_nxt_s = GAP;
          end else begin
            // Shift on high->low so the next bit leaves together with sclk falling.
            phase_nxt_s   = 1'b0;
            bit_idx_nxt_s = bit_idx_r - BW'(1);
            shift_nxt_s   = {shift_r[WIDTH-2:0], 1'b0};
          end
        end else begin
          div_cnt_nxt_s = div_cnt_r + DW'(1);
        end
      end
      GAP: begin
        if (div_cnt_r == DW'(CLK_DIV - 1)) begin
          div_cnt_nxt_s = {DW{1'b0}};
          state_nxt_s   = IDLE;
        end else begin
          div_cnt_nxt_s = div_cnt_r + DW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Transmitter state and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      div_cnt_r <= {DW{1'b0}};
      bit_idx_r <= {BW{1'b0}};
      phase_r   <= 1'b0;
      shift_r   <= {WIDTH{1'b0}};
      cs_n_r    <= 1'b1;
      sclk_r    <= 1'b0;
      sdo_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      div_cnt_r <= div_cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      phase_r   <= phase_nxt_s;
      shift_r   <= shift_nxt_s;
      cs_n_r    <= cs_n_nxt_s;
      sclk_r    <= sclk_nxt_s;
      sdo_r     <= sdo_nxt_s;
    end
  end

  assign cs_n       = cs_n_r;
  assign sclk       = sclk_r;
  assign sdo        = sdo_r;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_sar_result_reader.sv
// Testbench for sar_result_reader: directed scenarios plus random traffic,
// checked every cycle against a queue-and-timer reference model and a
// serial frame decoder.
module tb_sar_result_reader;

  localparam int WIDTH     = 12;
  localparam int DEPTH     = 4;
  localparam int CLK_DIV   = 2;
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int FRAME_LOW = 1 + 2 * CLK_DIV * WIDTH;   // cs_n low cycles
  localparam int BUSY0     = FRAME_LOW + CLK_DIV;       // cycles away from IDLE per frame
  localparam int PERIOD    = BUSY0 + 1;                 // back-to-back frame period

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             conv_done = 1'b0;
  logic [WIDTH-1:0] code = '0;
  logic             clr_ovf = 1'b0;
  logic             cs_n, sclk, sdo, overflow;
  logic [CW-1:0]    fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: FIFO contents, frames owed, remaining busy cycles
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_frames[$];
  int               busy;
  logic [WIDTH-1:0] tx_code;
  bit               cd_prev;
  bit               ovf;
  bit               e_cs_n, e_sclk, e_sdo;

  // frame decoder
  bit          m_in_frame;
  bit          m_sclk_prev;
  int          m_low, m_rises, frames_seen;
  logic [31:0] m_bits;

  sar_result_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .conv_done(conv_done), .code(code), .clr_ovf(clr_ovf),
    .cs_n(cs_n), .sclk(sclk), .sdo(sdo), .fifo_count(fifo_count), .overflow(overflow)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_frames.delete();
    busy    = 0;
    tx_code = '0;
    cd_prev = 1'b0;
    ovf     = 1'b0;
    e_cs_n  = 1'b1;
    e_sclk  = 1'b0;
    e_sdo   = 1'b0;
  endtask

  task automatic monitor_reset();
    m_in_frame  = 1'b0;
    m_sclk_prev = 1'b0;
    m_low       = 0;
    m_rises     = 0;
    m_bits      = '0;
  endtask

  // One rising edge of the model; pins seen after the edge show the previous cycle's activity.
  task automatic model_step();
    int               ob;
    int               o;
    int               bi;
    logic [WIDTH-1:0] oc;
    bit               push_m, pop_m, drop_m;
    ob      = busy;
    oc      = tx_code;
    push_m  = conv_done && !cd_prev;
    cd_prev = conv_done;
    pop_m   = (busy == 0) && (q.size() > 0);
    if (pop_m) begin
      tx_code = q.pop_front();
      exp_frames.push_back(tx_code);
      busy = BUSY0;
    end else if (busy > 0) begin
      busy--;
    end
    drop_m = 1'b0;
    if (push_m) begin
      if (q.size() < DEPTH) q.push_back(code);
      else drop_m = 1'b1;
    end
    if (drop_m) ovf = 1'b1;
    else if (clr_ovf) ovf = 1'b0;
    if (ob == BUSY0) begin
      e_cs_n = 1'b0; e_sclk = 1'b0; e_sdo = oc[WIDTH-1];
    end else if (ob > CLK_DIV) begin
      o      = BUSY0 - 1 - ob;
      bi     = o / (2 * CLK_DIV);
      e_cs_n = 1'b0;
      e_sclk = (o % (2 * CLK_DIV)) >= CLK_DIV;
      e_sdo  = oc[WIDTH-1-bi];
    end else begin
      e_cs_n = 1'b1; e_sclk = 1'b0; e_sdo = 1'b0;
    end
  endtask

  task automatic frame_end();
    check("frame_len", 32'(m_low), 32'(FRAME_LOW));
    check("frame_rises", 32'(m_rises), 32'(WIDTH));
    check("frame_expected", 32'(exp_frames.size() > 0), 32'd1);
    if (exp_frames.size() > 0) begin
      check("frame_code", m_bits, 32'(exp_frames.pop_front()));
    end
  endtask

  task automatic sample();
    check("cs_n", 32'(cs_n), 32'(e_cs_n));
    check("sclk", 32'(sclk), 32'(e_sclk));
    check("sdo", 32'(sdo), 32'(e_sdo));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(ovf));
    if (cs_n === 1'b0) begin
      if (!m_in_frame) begin
        m_in_frame = 1'b1; m_low = 0; m_rises = 0; m_bits = '0;
      end
      m_low++;
      if (sclk === 1'b1 && !m_sclk_prev) begin
        m_rises++;
        m_bits = {m_bits[30:0], sdo};
      end
    end else if (m_in_frame) begin
      m_in_frame = 1'b0;
      frames_seen++;
      frame_end();
    end
    m_sclk_prev = (sclk === 1'b1);
  endtask

  // Drive inputs (from a falling edge), take one rising edge, check at the next falling edge.
  task automatic cycle(input bit cd, input logic [WIDTH-1:0] c, input bit clr);
    conv_done = cd;
    code      = c;
    clr_ovf   = clr;
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    sample();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, WIDTH'($urandom), 1'b0);
  endtask

  task automatic pulses(input int n, input int gap, input logic [WIDTH-1:0] base);
    for (int k = 0; k < n; k++) begin
      cycle(1'b1, base + WIDTH'(k), 1'b0);
      idle(gap - 1);
    end
  endtask

  initial begin
    int guard;
    int frames_before;
    model_reset();
    monitor_reset();
    frames_seen = 0;
    #2 rst_n = 1'b0;

    // reset held with random inputs
    repeat (6) cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    conv_done = 1'b0;
    rst_n = 1'b1;
    idle(3);

    // single frame
    cycle(1'b1, 12'hA5C, 1'b0);
    idle(PERIOD + 10);
    check("single_frames", 32'(frames_seen), 32'd1);

    // held level gives exactly one push
    repeat (100) cycle(1'b1, 12'h123, 1'b0);
    idle(PERIOD + 10);
    check("held_frames", 32'(frames_seen), 32'd2);

    // overflow with codes 1..6 spaced 3 cycles
    pulses(6, 3, 12'h001);
    idle(PERIOD * 5 + 10);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_frames", 32'(frames_seen), 32'd7);
    cycle(1'b0, 12'h000, 1'b1);
    check("ovf_clr", 32'(overflow), 32'd0);
    // clr_ovf coincident with a drop
    pulses(5, 2, 12'h700);
    cycle(1'b1, 12'h705, 1'b1);
    check("ovf_clr_vs_drop", 32'(overflow), 32'd1);
    idle(PERIOD * 5 + 10);
    cycle(1'b0, 12'h000, 1'b1);
    check("ovf_clr2", 32'(overflow), 32'd0);

    // full FIFO, push lands exactly on the pop cycle
    pulses(5, 2, 12'h900);
    guard = 0;
    while (!(busy == 1 && q.size() == DEPTH) && guard < 200) begin
      idle(1);
      guard++;
    end
    check("full_wait_timeout", 32'(guard < 200), 32'd1);
    idle(1);
    cycle(1'b1, 12'hBEE, 1'b0);
    check("full_pp_cnt", 32'(fifo_count), 32'(DEPTH));
    check("full_pp_ovf", 32'(overflow), 32'd0);
    idle(PERIOD * 5 + 10);
    check("full_pp_drained", 32'(exp_frames.size()), 32'd0);

    // reset in the middle of a frame with two codes queued
    pulses(3, 2, 12'h300);
    guard = 0;
    while (!(m_in_frame && m_rises >= 5) && guard < 200) begin
      idle(1);
      guard++;
    end
    check("rise5_timeout", 32'(guard < 200), 32'd1);
    check("rst_pre_queue", 32'(fifo_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_cs_n", 32'(cs_n), 32'd1);
    check("rst_async_sclk", 32'(sclk), 32'd0);
    check("rst_async_sdo", 32'(sdo), 32'd0);
    check("rst_async_cnt", 32'(fifo_count), 32'd0);
    model_reset();
    monitor_reset();
    frames_before = frames_seen;
    repeat (3) cycle(1'b0, WIDTH'($urandom), 1'b0);
    rst_n = 1'b1;
    idle(PERIOD * 2);
    check("no_frame_after_rst", 32'(frames_seen), 32'(frames_before));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 9) == 0), WIDTH'($urandom), 1'($urandom_range(0, 63) == 0));
    end
    idle(PERIOD * (DEPTH + 2));
    check("final_frames_left", 32'(exp_frames.size()), 32'd0);
    check("final_count", 32'(fifo_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
